pipelined_carry_adder: RTL

- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits a DATA_WIDTH-bit addition into STAGES equal carry-chain segments, with one register boundary per segment.
- Carry-in, carry-out and an elastic valid/ready handshake on both sides.
- Sits in the datapath wherever a wide adder would break timing closure at the target clock.

---
 rtl/pca_pkg.sv | 11 +
 rtl/pca_segment_adder.sv | 14 +
 rtl/pipelined_carry_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pca_pkg.sv
// Shared defaults and helpers for the pipelined carry adder.
package pca_pkg;

    localparam int PCA_DATA_WIDTH_DEF = 32;
    localparam int PCA_STAGES_DEF     = 4;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pca_segment_adder.sv
// Combinational SEG_W-bit carry-chain segment: {cout, sum} = x + y + cin.
module pca_segment_adder #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined DATA_WIDTH adder, one carry segment per stage; optional ovf via PCA_SIGNED_OVF_EN.
// Latency STAGES cycles, one result per cycle.
// Backpressure: bubble-collapsing, ready ripples combinationally from out_ready to in_ready.
module pipelined_carry_adder
    import pca_pkg::*;
#(
    parameter int DATA_WIDTH = PCA_DATA_WIDTH_DEF,
    parameter int STAGES     = PCA_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
`ifdef PCA_SIGNED_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int SEG_W = seg_w(DATA_WIDTH, STAGES);

    if (STAGES < 1 || (DATA_WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_carry_adder: DATA_WIDTH must be a multiple of STAGES");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;

    // A stage may load when it is empty or everything downstream moves.
    always_comb begin
        logic chain;
        chain = out_ready;
        adv   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !vld[k] || chain;
            adv[k] = chain;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int INW = DATA_WIDTH - k * SEG_W;

        logic                  v_q;
        logic                  c_q;
        logic [DATA_WIDTH-1:0] s_q;
        logic [INW-1:0]        op_a;
        logic [INW-1:0]        op_b;
        logic                  ci;
        logic                  prev_v;
        logic [DATA_WIDTH-1:0] prev_s;
        logic [SEG_W-1:0]      seg_sum;
        logic                  co;
        logic [DATA_WIDTH-1:0] seg_ext;
`ifdef PCA_SIGNED_OVF_EN
        logic                  am_q;
        logic                  bm_q;
        logic                  prev_am;
        logic                  prev_bm;
`endif

        if (k == 0) begin : g_head
            assign op_a   = a;
            assign op_b   = b;
            assign ci     = cin;
            assign prev_v = in_valid;
            assign prev_s = '0;
`ifdef PCA_SIGNED_OVF_EN
            assign prev_am = a[DATA_WIDTH-1];
            assign prev_bm = b[DATA_WIDTH-1];
`endif
        end else begin : g_body
            assign op_a   = g_stage[k-1].g_ops.a_q;
            assign op_b   = g_stage[k-1].g_ops.b_q;
            assign ci     = g_stage[k-1].c_q;
            assign prev_v = g_stage[k-1].v_q;
            assign prev_s = g_stage[k-1].s_q;
`ifdef PCA_SIGNED_OVF_EN
            assign prev_am = g_stage[k-1].am_q;
            assign prev_bm = g_stage[k-1].bm_q;
`endif
        end

        pca_segment_adder #(
            .SEG_W(SEG_W)
        ) u_seg (
            .x    (op_a[SEG_W-1:0]),
            .y    (op_b[SEG_W-1:0]),
            .cin  (ci),
            .sum  (seg_sum),
            .cout (co)
        );

        assign seg_ext = DATA_WIDTH'(seg_sum) << (k * SEG_W);
        assign vld[k]  = v_q;

        // Data only loads with a valid entry so outputs hold across bubbles.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv[k]) begin
                v_q <= prev_v;
                if (prev_v) begin
                    c_q <= co;
                    s_q <= prev_s | seg_ext;
                end
            end
        end

`ifdef PCA_SIGNED_OVF_EN
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                am_q <= 1'b0;
                bm_q <= 1'b0;
            end else if (adv[k] && prev_v) begin
                am_q <= prev_am;
                bm_q <= prev_bm;
            end
        end
`endif

        if (k < STAGES - 1) begin : g_ops
            logic [INW-SEG_W-1:0] a_q;
            logic [INW-SEG_W-1:0] b_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k] && prev_v) begin
                    a_q <= op_a[INW-1:SEG_W];
                    b_q <= op_b[INW-1:SEG_W];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

`ifdef PCA_SIGNED_OVF_EN
    assign ovf = (g_stage[STAGES-1].am_q == g_stage[STAGES-1].bm_q) &&
                 (sum[DATA_WIDTH-1] != g_stage[STAGES-1].am_q);
`endif

endmodule
